// File: rtl/ub_bank_arbiter.sv
// Unified-buffer bank arbiter: per-bank DMA vs PE arbitration with starvation guard and 1-cycle read return.
// Optional performance counters are enabled by defining UB_ARB_PERF_EN.
module ub_bank_arbiter #(
  parameter  int DATA_W    = 16,
  parameter  int ADDR_W    = 10,
  parameter  int NB        = 4,
  parameter  int MAX_WAIT  = 4,
  localparam int BANK_BITS = $clog2(NB),
  localparam int GADDR_W   = ADDR_W + BANK_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [GADDR_W-1:0]   dma_addr,
  input  logic [DATA_W-1:0]    dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [DATA_W-1:0]    dma_rdata,
  input  logic [NB-1:0]        pe_req,
  input  logic [NB-1:0]        pe_we,
  input  logic [NB*ADDR_W-1:0] pe_addr,
  input  logic [NB*DATA_W-1:0] pe_wdata,
  output logic [NB-1:0]        pe_gnt,
  output logic [NB-1:0]        pe_rvalid,
  output logic [NB*DATA_W-1:0] pe_rdata,
  output logic [NB-1:0]        bank_en,
  output logic [NB-1:0]        bank_we,
  output logic [NB*ADDR_W-1:0] bank_addr,
  output logic [NB*DATA_W-1:0] bank_din,
  input  logic [NB*DATA_W-1:0] bank_dout
`ifdef UB_ARB_PERF_EN
  ,
  output logic [31:0]          conflict_cnt,
  output logic [15:0]          dma_forced_cnt
`endif
);

  logic [BANK_BITS-1:0] dma_bank;
  logic [ADDR_W-1:0]    dma_local;
  logic [7:0]           starve_cnt;
  logic                 dma_forced;
  logic [NB-1:0]        dma_hit;
  logic [NB-1:0]        dma_win;
  logic [NB-1:0]        pe_win;
  logic [BANK_BITS-1:0] dma_tag;

  // Low-order interleave: consecutive global words land in consecutive banks.
  assign dma_bank   = dma_addr[BANK_BITS-1:0];
  assign dma_local  = dma_addr[GADDR_W-1:BANK_BITS];
  assign dma_forced = (starve_cnt == 8'(MAX_WAIT));

  always_comb begin
    dma_hit = '0;
    if (dma_req && !reset) begin
      dma_hit[dma_bank] = 1'b1;
    end
  end

  // PE has priority on its own bank unless the DMA has been starved for MAX_WAIT cycles.
  always_comb begin
    dma_win   = '0;
    pe_win    = '0;
    bank_en   = '0;
    bank_we   = '0;
    bank_addr = '0;
    bank_din  = '0;
    for (int i = 0; i < NB; i++) begin
      if (!reset) begin
        if (dma_hit[i] && (!pe_req[i] || dma_forced)) begin
          dma_win[i]                     = 1'b1;
          bank_en[i]                     = 1'b1;
          bank_we[i]                     = dma_we;
          bank_addr[i*ADDR_W +: ADDR_W]  = dma_local;
          bank_din[i*DATA_W +: DATA_W]   = dma_wdata;
        end else if (pe_req[i]) begin
          pe_win[i]                      = 1'b1;
          bank_en[i]                     = 1'b1;
          bank_we[i]                     = pe_we[i];
          bank_addr[i*ADDR_W +: ADDR_W]  = pe_addr[i*ADDR_W +: ADDR_W];
          bank_din[i*DATA_W +: DATA_W]   = pe_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign dma_gnt = |dma_win;
  assign pe_gnt  = pe_win;

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!dma_req || dma_gnt) begin
      starve_cnt <= '0;
    end else if (!dma_forced) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end

  // Read tags: the bank answers one cycle later, so remember who asked and on which bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rvalid <= 1'b0;
      dma_tag    <= '0;
      pe_rvalid  <= '0;
    end else begin
      dma_rvalid <= dma_gnt && !dma_we;
      if (dma_gnt) begin
        dma_tag <= dma_bank;
      end
      pe_rvalid <= pe_win & ~pe_we;
    end
  end

  always_comb begin
    dma_rdata = '0;
    if (dma_rvalid) begin
      dma_rdata = bank_dout[int'(dma_tag)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    pe_rdata = '0;
    for (int i = 0; i < NB; i++) begin
      if (pe_rvalid[i]) begin
        pe_rdata[i*DATA_W +: DATA_W] = bank_dout[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef UB_ARB_PERF_EN
  logic conflict;
  assign conflict = dma_req && pe_req[dma_bank] && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt   <= '0;
      dma_forced_cnt <= '0;
    end else begin
      if (conflict && (conflict_cnt != 32'hFFFF_FFFF)) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      if (conflict && dma_gnt && dma_forced && (dma_forced_cnt != 16'hFFFF)) begin
        dma_forced_cnt <= dma_forced_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ub_bank_arbiter.sv
// Directed self-checking bench for ub_bank_arbiter with a 1-cycle-latency bank memory model.
// Define UB_ARB_PERF_EN to also check the performance counters.
module tb_ub_bank_arbiter;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int NB     = 4;
  localparam int GA_W   = 12;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 dma_req, dma_we;
  logic [GA_W-1:0]      dma_addr;
  logic [DATA_W-1:0]    dma_wdata;
  logic                 dma_gnt, dma_rvalid;
  logic [DATA_W-1:0]    dma_rdata;
  logic [NB-1:0]        pe_req, pe_we, pe_gnt, pe_rvalid;
  logic [NB*ADDR_W-1:0] pe_addr;
  logic [NB*DATA_W-1:0] pe_wdata, pe_rdata;
  logic [NB-1:0]        bank_en, bank_we;
  logic [NB*ADDR_W-1:0] bank_addr;
  logic [NB*DATA_W-1:0] bank_din, bank_dout;
`ifdef UB_ARB_PERF_EN
  logic [31:0]          conflict_cnt;
  logic [15:0]          dma_forced_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [NB][1024];

  always #5 clk = ~clk;

  ub_bank_arbiter dut (
    .clk(clk), .reset(reset),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .pe_req(pe_req), .pe_we(pe_we), .pe_addr(pe_addr), .pe_wdata(pe_wdata),
    .pe_gnt(pe_gnt), .pe_rvalid(pe_rvalid), .pe_rdata(pe_rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_din(bank_din), .bank_dout(bank_dout)
`ifdef UB_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt), .dma_forced_cnt(dma_forced_cnt)
`endif
  );

  // Bank model: synchronous write, registered read data one cycle after an enabled read.
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) mem[b][bank_addr[b*ADDR_W +: ADDR_W]] <= bank_din[b*DATA_W +: DATA_W];
        else bank_dout[b*DATA_W +: DATA_W] <= mem[b][bank_addr[b*ADDR_W +: ADDR_W]];
      end
    end
  end

  task automatic idle_inputs();
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    pe_req = '0; pe_we = '0; pe_addr = '0; pe_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    dma_req = 1'b1; pe_req = 4'b1111;
    next_cycle(); next_cycle();
    #1;
    checks++;
    if ({dma_gnt, pe_gnt, bank_en, bank_we} !== 13'd0) begin
      errors++; $display("[TB] FAIL rst_gnt_en: got %b want 0", {dma_gnt, pe_gnt, bank_en, bank_we});
    end
    checks++;
    if ({dma_rvalid, pe_rvalid, dma_rdata, pe_rdata} !== '0) begin
      errors++; $display("[TB] FAIL rst_rvalid: got dma=%b pe=%b want 0", dma_rvalid, pe_rvalid);
    end
    idle_inputs();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_dma_write();
    dma_req = 1; dma_we = 1; dma_addr = 12'h00D; dma_wdata = 16'hBEEF;
    #1;
    checks++;
    if (dma_gnt !== 1'b1 || bank_en !== 4'b0010 || bank_we !== 4'b0010) begin
      errors++; $display("[TB] FAIL wr_gnt: got gnt=%b en=%b we=%b want 1 0010 0010", dma_gnt, bank_en, bank_we);
    end
    checks++;
    if (bank_addr[ADDR_W +: ADDR_W] !== 10'd3 || bank_din[DATA_W +: DATA_W] !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL wr_addr_din: got %h %h want 003 beef", bank_addr[ADDR_W +: ADDR_W], bank_din[DATA_W +: DATA_W]);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dma_rvalid !== 1'b0) begin
      errors++; $display("[TB] FAIL wr_no_rvalid: got %b want 0", dma_rvalid);
    end
    next_cycle();
  endtask

  task automatic test_dma_read();
    dma_req = 1; dma_we = 0; dma_addr = 12'h00D;
    #1;
    checks++;
    if (dma_gnt !== 1'b1 || bank_we !== 4'b0000 || bank_en !== 4'b0010) begin
      errors++; $display("[TB] FAIL rd_gnt: got gnt=%b en=%b we=%b want 1 0010 0000", dma_gnt, bank_en, bank_we);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hBEEF || pe_rvalid !== 4'b0000) begin
      errors++; $display("[TB] FAIL rd_return: got v=%b d=%h pe=%b want 1 beef 0000", dma_rvalid, dma_rdata, pe_rvalid);
    end
    next_cycle();
    #1;
    checks++;
    if (dma_rvalid !== 1'b0 || dma_rdata !== 16'h0) begin
      errors++; $display("[TB] FAIL rd_clear: got v=%b d=%h want 0 0000", dma_rvalid, dma_rdata);
    end
  endtask

  // PE holds bank 1 (addr 5); DMA reads bank 1 local 2 (global 9) and must win at cycle 4.
  task automatic test_starvation();
    logic exp_dma, exp_pe, exp_pev;
    for (int c = 0; c <= 5; c++) begin
      pe_req = 4'b0010; pe_addr = '0; pe_addr[ADDR_W +: ADDR_W] = 10'd5;
      dma_req = (c <= 4); dma_we = 0; dma_addr = 12'd9;
      #1;
      exp_dma = (c == 4);
      exp_pe  = (c != 4);
      exp_pev = (c >= 1 && c != 5);
      checks++;
      if (dma_gnt !== exp_dma || pe_gnt[1] !== exp_pe) begin
        errors++; $display("[TB] FAIL starve_c%0d: got dma=%b pe=%b want %b %b", c, dma_gnt, pe_gnt[1], exp_dma, exp_pe);
      end
      checks++;
      if (pe_rvalid[1] !== exp_pev || pe_rdata[DATA_W +: DATA_W] !== (exp_pev ? 16'h1005 : 16'h0)) begin
        errors++; $display("[TB] FAIL starve_pe_ret_c%0d: got v=%b d=%h want %b", c, pe_rvalid[1], pe_rdata[DATA_W +: DATA_W], exp_pev);
      end
      if (c == 5) begin
        checks++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 16'h1002) begin
          errors++; $display("[TB] FAIL starve_dma_ret: got v=%b d=%h want 1 1002", dma_rvalid, dma_rdata);
        end
      end
      next_cycle();
    end
`ifdef UB_ARB_PERF_EN
    checks++;
    if (dma_forced_cnt !== 16'd1 || conflict_cnt !== 32'd5) begin
      errors++; $display("[TB] FAIL perf_cnt: got forced=%0d conflict=%0d want 1 5", dma_forced_cnt, conflict_cnt);
    end
`endif
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_parallel();
    dma_req = 1; dma_we = 0; dma_addr = 12'd30;
    pe_req = 4'b1011; pe_we = 4'b0000;
    pe_addr[0*ADDR_W +: ADDR_W] = 10'd1;
    pe_addr[1*ADDR_W +: ADDR_W] = 10'd4;
    pe_addr[3*ADDR_W +: ADDR_W] = 10'd9;
    #1;
    checks++;
    if (dma_gnt !== 1'b1 || pe_gnt !== 4'b1011 || bank_en !== 4'b1111) begin
      errors++; $display("[TB] FAIL par_gnt: got dma=%b pe=%b en=%b want 1 1011 1111", dma_gnt, pe_gnt, bank_en);
    end
    next_cycle();
    idle_inputs();
    #1;
    checks++;
    if (dma_rvalid !== 1'b1 || dma_rdata !== 16'h2007 || pe_rvalid !== 4'b1011) begin
      errors++; $display("[TB] FAIL par_valid: got dv=%b dd=%h pv=%b want 1 2007 1011", dma_rvalid, dma_rdata, pe_rvalid);
    end
    checks++;
    if (pe_rdata !== 64'h3009_0000_1004_0001) begin
      errors++; $display("[TB] FAIL par_pe_data: got %h want 3009000010040001", pe_rdata);
    end
    next_cycle();
  endtask

  // Build up starvation on bank 0, reset mid-conflict, then confirm the count restarted from 0.
  task automatic test_reset_midstream();
    dma_req = 1; dma_we = 0; dma_addr = 12'd4;
    pe_req = 4'b0001; pe_addr = '0; pe_addr[ADDR_W-1:0] = 10'd2;
    next_cycle(); next_cycle();
    reset = 1'b1;
    #1;
    checks++;
    if ({dma_gnt, pe_gnt, bank_en, bank_we} !== 13'd0 || bank_addr !== '0 || bank_din !== '0) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: got gnt=%b pe=%b en=%b want 0", dma_gnt, pe_gnt, bank_en);
    end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      dma_req = (c <= 4);
      #1;
      checks++;
      if (dma_gnt !== (c == 4)) begin
        errors++; $display("[TB] FAIL rst_mid_force_c%0d: got %b want %b", c, dma_gnt, (c == 4));
      end
      if (c == 0) begin
        checks++;
        if (dma_rvalid !== 1'b0 || pe_rvalid !== 4'b0000) begin
          errors++; $display("[TB] FAIL rst_mid_drop: got dv=%b pv=%b want 0 0000", dma_rvalid, pe_rvalid);
        end
      end
      if (c == 5) begin
        checks++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 16'h0001) begin
          errors++; $display("[TB] FAIL rst_mid_ret: got v=%b d=%h want 1 0001", dma_rvalid, dma_rdata);
        end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 5; c++) begin
      idle_inputs();
      if (c <= 3) begin
        pe_req = 4'b0001;
        pe_addr[ADDR_W-1:0] = 10'(c);
      end
      #1;
      if (c >= 1) begin
        checks++;
        if (pe_rvalid[0] !== (c <= 4) || pe_rdata[DATA_W-1:0] !== ((c <= 4) ? 16'(c - 1) : 16'h0)) begin
          errors++; $display("[TB] FAIL b2b_c%0d: got v=%b d=%h want %b", c, pe_rvalid[0], pe_rdata[DATA_W-1:0], (c <= 4));
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 1024; a++)
        mem[b][a] = 16'(b * 4096 + a);
    bank_dout = '0;
    test_reset();
    test_dma_write();
    test_dma_read();
    test_starvation();
    test_parallel();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ub_bank_arbiter.md
Name: ub_bank_arbiter

Overview:
- Sits between the DMA engine / PE array and the unified buffer's memory banks.
- Arbitrates, per bank, between the single global-address DMA port and that bank's dedicated PE port.
- Translates DMA global addresses to bank and local address, and returns read data with the correct 1-cycle bank latency and valid strobes.
- PE ports have default priority. A bounded starvation counter guarantees DMA forward progress.

Parameters:
DATA_W, 16, word width
ADDR_W, 10, local (per-bank) address width; DMA global address is ADDR_W+BANK_BITS wide
NB, 4, number of banks (power of 2, >=2); BANK_BITS = $clog2(NB)
MAX_WAIT, 4, consecutive blocked DMA cycles before DMA is forced to win (1..255)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dma_req  in  1  DMA request; held stable with addr/we/wdata until dma_gnt
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W+BANK_BITS  global word address
dma_wdata  in  DATA_W  write data
dma_gnt  out  1  request accepted this cycle (combinational)
dma_rvalid  out  1  read data valid
dma_rdata  out  DATA_W  read data
pe_req  in  NB  per-bank PE request
pe_we  in  NB  per-bank write select
pe_addr  in  NB*ADDR_W  per-bank local address
pe_wdata  in  NB*DATA_W  per-bank write data
pe_gnt  out  NB  per-bank accept (combinational)
pe_rvalid  out  NB  per-bank read data valid
pe_rdata  out  NB*DATA_W  per-bank read data
bank_en  out  NB  bank access enable
bank_we  out  NB  bank write enable
bank_addr  out  NB*ADDR_W  bank local address
bank_din  out  NB*DATA_W  bank write data
bank_dout  in  NB*DATA_W  bank read data, valid 1 cycle after an enabled read

Behaviour:
- Address split: dma_bank = dma_addr[BANK_BITS-1:0] (low-order interleave); dma_local = dma_addr[ADDR_W+BANK_BITS-1:BANK_BITS].
- Per-bank arbitration, bank i, cycle N:
  - Only one of DMA (dma_req && dma_bank==i) and pe_req[i] requests: that requester wins.
  - Both request: PE wins unless starve_cnt == MAX_WAIT, in which case DMA wins.
  - The winner drives bank_en[i]=1, bank_we[i], bank_addr[i], bank_din[i]; its gnt=1.
  - No winner: bank_en[i]=0, bank_we[i]=0, addr/din = 0.
- Never drive a bank from both sources. Never assert bank_we without bank_en.
- starve_cnt (8-bit register), updated at clock edge:
  - Clears when dma_gnt=1 or dma_req=0.
  - Increments when dma_req=1 and dma_gnt=0.
  - Saturates at MAX_WAIT.
  - Worst-case DMA wait is therefore MAX_WAIT cycles.
- Read return, latency exactly 1 cycle:
  - Granted DMA read at N: at N+1, dma_rvalid=1 and dma_rdata=bank_dout[bank registered at N].
  - Granted PE read on bank i at N: at N+1, pe_rvalid[i]=1 and pe_rdata[i]=bank_dout[i].
  - Writes produce no rvalid.
  - A DMA read and a PE read on different banks in the same cycle both return at N+1.
- rdata outputs are 0 whenever the corresponding rvalid=0.
- Back-to-back granted reads every cycle are supported with no bubbles.
- Reset (synchronous, active-high):
  - starve_cnt=0, dma_rvalid=0, pe_rvalid=0, registered bank tag=0.
  - gnt and bank_* outputs are 0 while reset=1, regardless of requests.
  - A read granted in the cycle reset is asserted is dropped (no rvalid afterwards).
- Protocol violation (DMA changes addr/we before gnt): not detected; the arbiter uses current-cycle values.

Optional Feature:
UB_ARB_PERF_EN
- Defined:
  - Adds output conflict_cnt (32 bits): counts cycles where DMA and a PE requested the same bank. Saturating at 2^32-1; cleared by reset.
  - Adds output dma_forced_cnt (16 bits, saturating): counts grants won via starve_cnt==MAX_WAIT.
- Undefined: both ports and counters are absent; arbitration behaviour is identical.

Test Plan:
- DMA write addr 0x00D, data 0xBEEF, NB=4, no PE traffic -> dma_gnt same cycle; bank_en[1]=1, bank_we[1]=1, bank_addr[1]=3, bank_din[1]=0xBEEF.
- DMA read addr 0x00D, bank model returns 0xBEEF -> dma_rvalid=1 and dma_rdata=0xBEEF exactly one cycle after gnt; all pe_rvalid=0.
- pe_req[1] held continuously, DMA read to bank 1, MAX_WAIT=4 -> PE granted cycles 0-3, DMA granted cycle 4 with pe_gnt[1]=0 that cycle, PE granted again cycle 5; dma_forced_cnt=1 when UB_ARB_PERF_EN is defined.
- Same cycle: DMA read bank 2, PE reads on banks 0/1/3 -> all four granted; next cycle dma_rvalid=1 and pe_rvalid=4'b1011 with matching data.
- Reset asserted in the same cycle as a granted DMA read -> no dma_rvalid in any following cycle; all outputs 0 during reset; starve_cnt=0 afterwards (verified by the next conflict taking 4 cycles to force).
- Four back-to-back PE reads on bank 0, addresses 0-3 -> pe_rvalid[0] high for four consecutive cycles, data in address order.
